// File: rtl/demux_scheduler_pkg.sv
// Shared definitions for the demux burst scheduler: FSM encoding and channel geometry.
package demux_scheduler_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

endpackage

// File: rtl/demux_scheduler_demux1to4.sv
// Plain 1-to-4 demultiplexer; the scheduler is its only controller.
module demux1to4 (
    input  logic       data,
    input  logic [1:0] sel,
    input  logic       enable,
    output logic [3:0] out
);

    always_comb begin
        out = 4'b0000;
        if (enable) begin
            out[sel] = data;
        end
    end

endmodule

// File: rtl/demux_scheduler.sv
// Round-robin burst scheduler sharing one serial stream among four demux channels.
//
// state | meaning
// IDLE  | demux disabled, arbitrate among ready channels when a word is waiting
// XFER  | grant held on sel, move BURST words, stall while producer/consumer idle
module demux_scheduler
    import demux_scheduler_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_data,
    output logic             in_ready,
    input  logic [NUM_CH-1:0] ch_ready,
    input  logic             flush,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] ch_valid,
    output logic [CH_W-1:0]  sel,
    output logic             enable,
    output logic             burst_done
);

    state_t           state;
    logic [CH_W-1:0]  ptr;
    logic [CNT_W-1:0] cnt;
    logic             handshake;
    logic             last_word;
    logic [CH_W-1:0]  winner;

    // First ready channel scanning ptr, ptr+1, ... ; ptr when none is ready (unused then).
    function automatic logic [CH_W-1:0] rr_winner(input logic [CH_W-1:0] p,
                                                  input logic [NUM_CH-1:0] rdy);
        logic [CH_W-1:0] idx;
        rr_winner = p;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = p + CH_W'(k);
            if (rdy[idx]) begin
                rr_winner = idx;
            end
        end
    endfunction

    assign winner    = rr_winner(ptr, ch_ready);
    assign in_ready  = (state == ST_XFER) && ch_ready[sel];
    assign handshake = in_valid && in_ready;
    assign last_word = (cnt == CNT_W'(BURST - 1));

    always_comb begin
        ch_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_valid[i] = enable && (sel == CH_W'(i)) && in_valid && ch_ready[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            sel        <= '0;
            enable     <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && (|ch_ready) && !flush) begin
                        sel    <= winner;
                        cnt    <= '0;
                        enable <= 1'b1;
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Flush takes priority over a final handshake: the word goes through, no done pulse.
                    if (flush) begin
                        ptr    <= sel + 1'b1;
                        cnt    <= '0;
                        enable <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (handshake) begin
                        if (last_word) begin
                            burst_done <= 1'b1;
                            ptr        <= sel + 1'b1;
                            cnt        <= '0;
                            enable     <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    enable <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    demux1to4 u_demux (
        .data   (in_data),
        .sel    (sel),
        .enable (enable),
        .out    (out)
    );

endmodule
